// File: rtl/isa_pkg.sv
// Shared encodings for the MEM-stage data access unit: load funct3 codes,
// store size codes and the access FSM states.
package isa_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_SB = 2'b00;
    localparam logic [1:0] SZ_SH = 2'b01;
    localparam logic [1:0] SZ_SW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Word-wide request/acknowledge port between the access unit (master)
// and data memory (slave).
interface data_mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  DMEM_REQ;
    logic                  DMEM_WE;
    logic [ADDR_WIDTH-1:0] DMEM_ADDR;
    logic [3:0]            DMEM_BE;
    logic [31:0]           DMEM_WDATA;
    logic [31:0]           DMEM_RDATA;
    logic                  DMEM_ACK;

    modport master (
        output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA,
        input  DMEM_RDATA, DMEM_ACK
    );

    modport slave (
        input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA,
        output DMEM_RDATA, DMEM_ACK
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables / data steering with legality
// checks, and load byte/half extraction with sign or zero extension.
module load_store_align
    import isa_pkg::*;
(
    input  logic        i_ld_en,
    input  logic [2:0]  i_ld_funct3,
    input  logic        i_st_en,
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_illegal,
    input  logic [2:0]  i_rd_funct3,
    input  logic [1:0]  i_rd_lsb,
    input  logic [31:0] i_rd_word,
    output logic [31:0] o_rd_data
);

    logic [31:0] w_rd_shift;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statements can leave a value held, which would infer a latch.
        o_be      = 4'b0000;
        o_wdata   = 32'h0;
        o_illegal = 1'b0;
        if (i_ld_en && i_st_en) begin
            o_illegal = 1'b1;
        end else if (i_ld_en) begin
            o_be = 4'b1111;
            case (i_ld_funct3)
                F3_LB, F3_LBU: o_illegal = 1'b0;
                F3_LH, F3_LHU: o_illegal = i_addr_lsb[0];
                F3_LW:         o_illegal = |i_addr_lsb;
                default:       o_illegal = 1'b1;
            endcase
        end else if (i_st_en) begin
            case (i_st_size)
                SZ_SB: begin
                    o_be    = 4'b0001 << i_addr_lsb;
                    o_wdata = {4{i_st_data[7:0]}};
                end
                SZ_SH: begin
                    o_be      = i_addr_lsb[1] ? 4'b1100 : 4'b0011;
                    o_wdata   = {2{i_st_data[15:0]}};
                    o_illegal = i_addr_lsb[0];
                end
                SZ_SW: begin
                    o_be      = 4'b1111;
                    o_wdata   = i_st_data;
                    o_illegal = |i_addr_lsb;
                end
                default: o_illegal = 1'b1;
            endcase
        end
    end

    assign w_rd_shift = i_rd_word >> {i_rd_lsb, 3'b000};
    assign w_rd_byte  = w_rd_shift[7:0];
    assign w_rd_half  = i_rd_lsb[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    always_comb begin
        case (i_rd_funct3)
            F3_LB:   o_rd_data = {{24{w_rd_byte[7]}}, w_rd_byte};
            F3_LBU:  o_rd_data = {24'h0, w_rd_byte};
            F3_LH:   o_rd_data = {{16{w_rd_half[15]}}, w_rd_half};
            F3_LHU:  o_rd_data = {16'h0, w_rd_half};
            default: o_rd_data = i_rd_word;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit: turns decoded memory codes into a word-aligned,
// byte-enabled req/ack transaction, stalls via BUSY and returns load data.
module data_mem_access_unit
    import isa_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            MEM_READ,
    input  logic [2:0]            MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    output logic [31:0]           READ_DATA,
    output logic                  BUSY,
    output logic                  FAULT,
    data_mem_access_unit_if.master dmem
);

    localparam bit TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_INT = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_INT[CNT_W-1:0];

    state_t                r_state;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic [1:0]            r_lsb;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_read_data;
    logic                  r_fault;

    logic        w_req;
    logic        w_accept;
    logic        w_illegal;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    load_store_align u_align (
        .i_ld_en     (MEM_READ[3]),
        .i_ld_funct3 (MEM_READ[2:0]),
        .i_st_en     (MEM_WRITE[2]),
        .i_st_size   (MEM_WRITE[1:0]),
        .i_addr_lsb  (ADDRESS[1:0]),
        .i_st_data   (WRITE_DATA),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_illegal   (w_illegal),
        .i_rd_funct3 (r_funct3),
        .i_rd_lsb    (r_lsb),
        .i_rd_word   (dmem.DMEM_RDATA),
        .o_rd_data   (w_ld_data)
    );

    // The instruction right behind a faulting one is flushed by the trap,
    // so it is not accepted while FAULT is high; this keeps FAULT and BUSY disjoint.
    assign w_req     = MEM_READ[3] | MEM_WRITE[2];
    assign w_accept  = (r_state == ST_IDLE) && w_req && !r_fault;
    assign w_timeout = TO_EN && (r_cnt == CNT_LAST);
    assign BUSY      = RESET && ((w_accept && !w_illegal) || (r_state == ST_REQ));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= 4'b0000;
            r_wdata     <= 32'h0;
            r_funct3    <= 3'b000;
            r_lsb       <= 2'b00;
            r_cnt       <= '0;
            r_read_data <= 32'h0;
            r_fault     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here, so every register
            // samples the pre-edge values regardless of statement order.
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_illegal) begin
                        r_fault <= 1'b1;
                    end else if (w_accept) begin
                        r_req    <= 1'b1;
                        r_we     <= MEM_WRITE[2];
                        r_addr   <= {ADDRESS[ADDR_WIDTH-1:2], 2'b00};
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_funct3 <= MEM_READ[2:0];
                        r_lsb    <= ADDRESS[1:0];
                        r_cnt    <= '0;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem.DMEM_ACK) begin
                        r_req <= 1'b0;
                        if (!r_we) r_read_data <= w_ld_data;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        if (!r_we) r_read_data <= 32'h0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign READ_DATA       = r_read_data;
    assign FAULT           = r_fault;
    assign dmem.DMEM_REQ   = r_req;
    assign dmem.DMEM_WE    = r_we;
    assign dmem.DMEM_ADDR  = r_addr;
    assign dmem.DMEM_BE    = r_be;
    assign dmem.DMEM_WDATA = r_wdata;

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
MEM-stage consumer of the decoder's memory control codes: main_mem_read {en, funct3} and main_mem_write {en, funct3[1:0]}.
- Converts a load/store into a word-aligned, byte-enabled request/acknowledge transaction on the data-memory port.
- Stalls the pipeline via BUSY until the access completes.
- Returns sign- or zero-extended load data.
- Sits between the EX/MEM pipeline register and data memory.

Parameters:
TIMEOUT_CYCLES, 64, max cycles waiting for MEM_ACK before fault; 0 disables timeout.
ADDR_WIDTH, 32, byte address width.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-low reset.
MEM_READ  input  4  [3] load enable, [2:0] funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
MEM_WRITE  input  3  [2] store enable, [1:0] size (00 SB, 01 SH, 10 SW).
ADDRESS  input  ADDR_WIDTH  byte address from ALU.
WRITE_DATA  input  32  store data (rs2).
READ_DATA  output  32  extended load result, registered.
BUSY  output  1  stall request to the pipeline.
FAULT  output  1  one-cycle pulse: misaligned, illegal code, or timeout.
DMEM_REQ  output  1  memory request, held until ack.
DMEM_WE  output  1  1 = write.
DMEM_ADDR  output  ADDR_WIDTH  word-aligned address ([1:0]=00).
DMEM_BE  output  4  byte enables.
DMEM_WDATA  output  32  lane-steered store data.
DMEM_RDATA  input  32  raw read word.
DMEM_ACK  input  1  access complete; RDATA valid in the same cycle.

Behaviour:
- Reset (RESET low, asynchronous):
  - State IDLE.
  - READ_DATA=0, FAULT=0, DMEM_REQ=0, DMEM_WE=0, DMEM_BE=0, DMEM_ADDR=0, DMEM_WDATA=0, timeout counter=0.
  - Reset asserted mid-transaction abandons it; no ack is expected afterwards.
- State IDLE:
  - req = MEM_READ[3] | MEM_WRITE[2].
  - Legal request: exactly one enable set, legal code, aligned address.
    - BUSY=1 combinationally in the same cycle.
    - Latch the word address, BE, steered WDATA, WE and load funct3 into DMEM_* registers.
    - Next state REQ.
  - Illegal request:
    - Illegal means: both enables set; load funct3 011/110/111; store size 11; LH/LHU/SH with ADDRESS[0]=1; LW/SW with ADDRESS[1:0]≠00.
    - FAULT pulses next cycle, BUSY stays 0, no memory access, READ_DATA unchanged.
- State REQ:
  - DMEM_REQ=1 and BUSY=1; DMEM_* outputs stable until ack.
  - On DMEM_ACK:
    - Loads register the extended data into READ_DATA.
    - DMEM_REQ drops next cycle.
    - Next state DONE.
  - Timeout: counter increments each REQ cycle without ack. When count = TIMEOUT_CYCLES-1 with no ack (TIMEOUT_CYCLES>0):
    - FAULT pulse, READ_DATA=0 for loads, next state DONE.
    - A late ack arriving in DONE/IDLE is ignored.
- State DONE:
  - BUSY=0 for exactly one cycle so the pipeline advances; the instruction still presented is not reissued.
  - Next state IDLE unconditionally.
  - Minimum latency: request cycle → DONE is 2 cycles with ack in the first REQ cycle.
- Store lane steering:
  - SB: BE = 0001 << ADDRESS[1:0], WDATA = byte replicated ×4.
  - SH: BE = 0011 or 1100 by ADDRESS[1], WDATA = halfword replicated ×2.
  - SW: BE=1111.
- Load extraction from DMEM_RDATA:
  - Select the byte/half by latched ADDRESS[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - DMEM_BE=1111 for all loads.
- READ_DATA holds its value until the next completed load; stores never change it.
- FAULT is never asserted in the same cycle as BUSY.

Decomposition:
- Shared package (isa_pkg):
  - Load funct3 constants LB/LH/LW/LBU/LHU.
  - Store size constants SB/SH/SW.
  - State encoding IDLE/REQ/DONE.
- Sub-module load_store_align (combinational):
  - Store direction: BE and WDATA generation plus misalignment/illegal detection.
  - Load direction: byte/half selection and sign/zero extension.
  - Instantiated once; the FSM and timeout counter stay in the top.

Test Plan:
- SB 0xA5 to address 0x103, ack after 3 cycles → DMEM_ADDR=0x100, BE=1000, WDATA=0xA5A5A5A5, BUSY high 4 cycles, then one low DONE cycle.
- LB at 0x102 with RDATA=0x00800000, immediate ack → READ_DATA=0xFFFFFF80; LBU same → 0x00000080; LH at 0x102 with RDATA=0x80010000 → 0xFFFF8001.
- LW at 0x206 → FAULT pulse, no DMEM_REQ, BUSY=0, READ_DATA unchanged; MEM_READ=1_011 → FAULT.
- LW at 0x40 with TIMEOUT_CYCLES=4 and no ack → FAULT after 4 REQ cycles, READ_DATA=0, DONE, IDLE; late ack ignored.
- Back-to-back SW 0x12345678 @0x10 then LW @0x10 (memory model returns written data) → second request starts the cycle after DONE, READ_DATA=0x12345678.
- RESET low during REQ → DMEM_REQ=0, BUSY=0, READ_DATA=0 immediately; release → IDLE, new request serviced normally.
